// File: rtl/neuron_mac_if.sv
// Bundle of activation stream, weight-memory read port and result signals for neuron_mac.
// The master side is the upstream source plus the weight memory; the slave side is the neuron.
interface neuron_mac_if #(
    parameter int dataWidth    = 16,
    parameter int addressWidth = 5
);
    logic                    x_valid;
    logic [dataWidth-1:0]    x_in;
    logic [dataWidth-1:0]    bias;
    logic                    w_ren;
    logic [addressWidth-1:0] w_radd;
    logic [dataWidth-1:0]    w_in;
    logic                    out_valid;
    logic [dataWidth-1:0]    out;

    modport master (
        output x_valid, x_in, bias, w_in,
        input  w_ren, w_radd, out_valid, out
    );

    modport slave (
        input  x_valid, x_in, bias, w_in,
        output w_ren, w_radd, out_valid, out
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate stage: streams activations, reads one weight per
// activation from the neuron's weight memory, accumulates x*w, adds bias and applies
// a saturating ReLU. One result pulse per vector of numWeight activations.
module neuron_mac #(
    parameter int numWeight    = 30,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12,
    parameter int addressWidth = $clog2(numWeight),
    parameter int accWidth     = 2*dataWidth + $clog2(numWeight)
) (
    input logic         clk,
    input logic         rst_n,
    neuron_mac_if.slave bus
);
    localparam int prodWidth = 2*dataWidth;
    // one spare bit so the bias addition can never wrap the sum
    localparam int sumWidth  = accWidth + 1;
    localparam logic [addressWidth-1:0] last_idx = addressWidth'(numWeight - 1);

    logic [addressWidth-1:0] cnt;
    logic                    accept;

    logic                        s1_valid, s1_first, s1_last;
    logic signed [dataWidth-1:0] s1_x;

    logic                        s2_valid, s2_first, s2_last;
    logic signed [prodWidth-1:0] s2_p;

    logic signed [accWidth-1:0]  acc;
    logic                        s3_last;

    logic                        out_valid_q;
    logic [dataWidth-1:0]        out_q;

    logic signed [prodWidth-1:0] x_ext, w_ext, prod;
    logic signed [accWidth-1:0]  p_ext;
    logic signed [sumWidth-1:0]  acc_ext, bias_ext, sum, r;
    logic [dataWidth-1:0]        res;

    assign accept     = bus.x_valid;
    // weight read is issued in the same cycle the activation is accepted; the
    // memory answers one cycle later, lining up with stage 1
    assign bus.w_ren  = bus.x_valid & rst_n;
    assign bus.w_radd = cnt;

    // element index within the current vector, advances only on accepted elements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (cnt == last_idx) ? '0 : cnt + addressWidth'(1);
        end
    end

    // stage 1: capture activation and first/last tags; weight arrives this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
        end else begin
            s1_valid <= accept;
            s1_first <= accept && (cnt == '0);
            s1_last  <= accept && (cnt == last_idx);
            if (accept) begin
                s1_x <= bus.x_in;
            end
        end
    end

    // full-precision signed product; memory output is masked when no element is in stage 1
    always_comb begin
        x_ext = {{dataWidth{s1_x[dataWidth-1]}}, s1_x};
        w_ext = {{dataWidth{bus.w_in[dataWidth-1]}}, bus.w_in};
        prod  = s1_valid ? x_ext * w_ext : '0;
    end

    // stage 2: register the product and forward the tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_p     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_p     <= prod;
        end
    end

    // sign-extend the product to accumulator width
    always_comb begin
        p_ext = {{(accWidth-prodWidth){s2_p[prodWidth-1]}}, s2_p};
    end

    // stage 3: accumulate; the first tag restarts the sum so vectors can abut with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            s3_last <= 1'b0;
        end else begin
            s3_last <= s2_valid & s2_last;
            if (s2_valid) begin
                acc <= s2_first ? p_ext : acc + p_ext;
            end
        end
    end

    // add bias aligned to the product's fixed point, rescale, then clamp to [0, max positive]
    always_comb begin
        acc_ext  = {{(sumWidth-accWidth){acc[accWidth-1]}}, acc};
        bias_ext = {{(sumWidth-dataWidth){bus.bias[dataWidth-1]}}, bus.bias};
        sum      = acc_ext + (bias_ext <<< fracBits);
        r        = sum >>> fracBits;
        if (r[sumWidth-1]) begin
            res = '0;
        end else if (|r[sumWidth-2:dataWidth-1]) begin
            res = {1'b0, {(dataWidth-1){1'b1}}};
        end else begin
            res = r[dataWidth-1:0];
        end
    end

    // stage 4: publish the result for one cycle; out holds until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= s3_last;
            if (s3_last) begin
                out_q <= res;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: behavioural dot-product model with a result queue,
// per-cycle comparison of handshake and result outputs, directed cases plus random vectors.
module tb_neuron_mac;
    localparam int NW = 30;
    localparam int DW = 16;
    localparam int FB = 12;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_mac_if #(.dataWidth(DW), .addressWidth(AW)) bus();

    neuron_mac #(.numWeight(NW), .dataWidth(DW), .fracBits(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] wmem [NW];
    int cyc   = 0;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // weight memory: registered read, no reset
    always @(posedge clk) begin
        if (bus.w_ren) bus.w_in <= wmem[bus.w_radd];
    end

    // ---------------- behavioural model ----------------
    int            k_m    = 0;
    longint        acc_m  = 0;
    longint        prod_m = 0;
    logic [DW-1:0] hold_m = '0;
    int            due_q[$];
    logic [DW-1:0] val_q[$];
    logic [DW-1:0] seen_val[$];
    int            seen_cyc[$];

    function automatic logic [DW-1:0] finalize(input longint s_acc, input logic [DW-1:0] b);
        longint s, r;
        s = s_acc + longint'($signed(b)) * (longint'(1) << FB);
        r = s >>> FB;
        if (r < 0) return '0;
        if (r > 32767) return 16'h7FFF;
        return r[DW-1:0];
    endfunction

    // dot product of element k with weight k; result due four cycles after the last element
    always @(posedge clk) begin
        if (rst_n && bus.x_valid) begin
            prod_m = longint'($signed(bus.x_in)) * longint'($signed(wmem[k_m]));
            if (k_m == 0) acc_m = prod_m;
            else          acc_m = acc_m + prod_m;
            if (k_m == NW-1) begin
                due_q.push_back(cyc + 4);
                val_q.push_back(finalize(acc_m, bus.bias));
                k_m = 0;
            end else begin
                k_m++;
            end
        end
        cyc++;
    end

    always @(negedge rst_n) begin
        k_m    = 0;
        acc_m  = 0;
        hold_m = '0;
        due_q.delete();
        val_q.delete();
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        bit exp_v;
        check("w_ren", bus.w_ren, rst_n & bus.x_valid);
        if (bus.w_ren) check("w_radd", bus.w_radd, k_m);
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end
        exp_v = (due_q.size() > 0 && due_q[0] == cyc);
        check("out_valid", bus.out_valid, exp_v);
        if (exp_v) begin
            hold_m = val_q.pop_front();
            void'(due_q.pop_front());
        end
        if (bus.out_valid) begin
            seen_val.push_back(bus.out);
            seen_cyc.push_back(cyc);
        end
        check("out", bus.out, hold_m);
    end

    // ---------------- stimulus ----------------
    task automatic fill(input logic [DW-1:0] w);
        for (int i = 0; i < NW; i++) wmem[i] = w;
    endtask

    task automatic send(input logic [DW-1:0] xv, input int maxgap, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                bus.x_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.x_valid = 1'b1;
            bus.x_in    = rnd ? DW'($urandom) : xv;
            @(posedge clk); #1;
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.x_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_one(input string name, input int base, input logic [DW-1:0] lit);
        check({name, "_count"}, seen_val.size() - base, 1);
        if (seen_val.size() > base) check({name, "_val"}, seen_val[base], lit);
        check({name, "_model"}, hold_m, lit);
    endtask

    initial begin
        int base;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.bias    = '0;
        fill(16'h0100);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", bus.out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        idle(2);

        // basic MAC: 30 * (1.0 * 1/16) = 1.875
        base = seen_val.size();
        send(16'h1000, 0, NW, 1'b0);
        idle(8);
        expect_one("basic", base, 16'h1E00);

        // positive saturation: 15 + 0.25
        fill(16'h1000);
        bus.bias = 16'h0400;
        base = seen_val.size();
        send(16'h0800, 0, NW, 1'b0);
        idle(8);
        expect_one("sat", base, 16'h7FFF);

        // ReLU: -30 + 1
        fill(16'hF000);
        bus.bias = 16'h1000;
        base = seen_val.size();
        send(16'h1000, 0, NW, 1'b0);
        idle(8);
        expect_one("relu", base, 16'h0000);

        // gapped input
        fill(16'h0100);
        bus.bias = 16'h0000;
        base = seen_val.size();
        send(16'h1000, 3, NW, 1'b0);
        idle(8);
        expect_one("gapped", base, 16'h1E00);

        // back-to-back vectors
        base = seen_val.size();
        send(16'h1000, 0, NW, 1'b0);
        send(16'h2000, 0, NW, 1'b0);
        idle(8);
        check("b2b_count", seen_val.size() - base, 2);
        if (seen_val.size() >= base + 2) begin
            check("b2b_first", seen_val[base], 16'h1E00);
            check("b2b_second", seen_val[base+1], 16'h3C00);
            check("b2b_spacing", seen_cyc[base+1] - seen_cyc[base], 30);
        end
        check("b2b_model", hold_m, 16'h3C00);

        // reset after 10 elements, with x_valid held high through reset
        send(16'h1000, 0, 10, 1'b0);
        bus.x_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        check("midrst_w_ren", bus.w_ren, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out", bus.out, 0);
        repeat (2) @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        base = seen_val.size();
        send(16'h1000, 0, NW, 1'b0);
        idle(8);
        expect_one("after_rst", base, 16'h1E00);

        // random vectors: random weights, activations, bias and gaps
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < NW; i++) wmem[i] = DW'($urandom);
            bus.bias = DW'($urandom);
            base = seen_val.size();
            send(16'h0000, (v % 3), NW, 1'b1);
            idle(8);
            check("rand_count", seen_val.size() - base, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_mis++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "timeout");
    end

endmodule
